// File: rtl/or_gate.sv
// ----------------------------------------------------------------------------
// or_gate
//   Parameterised 2-input bitwise OR primitive for the gate library.
//   The combinational result q = a | b and its reduction q_any have zero
//   latency. When REG_EN=1 there is also a registered copy for clocked
//   consumers:
//     q_reg        : holds the last a | b that was accepted
//     q_valid      : one-cycle pulse after each accepted result
//     q_any_sticky : any-high flag that stays set until cleared
//   When REG_EN=0 the registered outputs are tied to their reset values.
//
// Parameters
//   WIDTH   bit width of a, b, q, q_reg
//   REG_EN  1 = registered path present, 0 = registered outputs tied low
//
// Ports
//   clk           in   1      rising-edge clock for all registered logic
//   rst_n         in   1      asynchronous active-low reset
//   a, b          in   WIDTH  operands
//   in_valid      in   1      qualifies a/b for the registered path
//   clr_sticky    in   1      synchronous clear of q_any_sticky
//   q             out  WIDTH  combinational a | b
//   q_any         out  1      combinational |q
//   q_reg         out  WIDTH  registered a | b, captured when in_valid=1
//   q_valid       out  1      high one cycle after each accepted in_valid
//   q_any_sticky  out  1      set by any nonzero accepted result
// ----------------------------------------------------------------------------
module or_gate #(
    parameter int WIDTH  = 1,
    parameter bit REG_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] q,
    output logic             q_any,
    output logic [WIDTH-1:0] q_reg,
    output logic             q_valid,
    output logic             q_any_sticky
);

    // Any bit set in a vector; kept as a function so the combinational
    // flag and the sticky set condition share one definition.
    function automatic logic any_high(input logic [WIDTH-1:0] v);
        return |v;
    endfunction

    // Stage p0: combinational OR. The bitwise operator already gives the
    // required X behaviour: a known 1 on either side forces a 1.
    logic [WIDTH-1:0] q_p0;
    logic             vld_p0;

    assign q_p0   = a | b;
    assign vld_p0 = in_valid;
    assign q      = q_p0;
    assign q_any  = any_high(q_p0);

    generate
        if (REG_EN) begin : g_reg
            logic [WIDTH-1:0] q_p1;
            logic             vld_p1;
            logic             sticky_p1;

            // Stage p1: registered copy. The data register is reset as well
            // so q_reg reads zero during and right after reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_p1      <= '0;
                    vld_p1    <= 1'b0;
                    sticky_p1 <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        q_p1 <= q_p0;
                    end
                    // Set has priority over clear on the same edge.
                    if (vld_p0 && any_high(q_p0)) begin
                        sticky_p1 <= 1'b1;
                    end else if (clr_sticky) begin
                        sticky_p1 <= 1'b0;
                    end
                end
            end

            assign q_reg        = q_p1;
            assign q_valid      = vld_p1;
            assign q_any_sticky = sticky_p1;
        end else begin : g_noreg
            // Clocked inputs have no load in this configuration.
            logic unused_ctrl;
            assign unused_ctrl  = ^{clk, rst_n, in_valid, clr_sticky};

            assign q_reg        = '0;
            assign q_valid      = 1'b0;
            assign q_any_sticky = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_or_gate.sv
module tb_or_gate;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       in_valid, clr_sticky;

    // WIDTH=8 registered instance
    logic [7:0] q8, q_reg8;
    logic       q_any8, q_valid8, q_sticky8;
    // WIDTH=8, REG_EN=0 instance sharing the same inputs
    logic [7:0] qn, q_regn;
    logic       q_anyn, q_validn, q_stickyn;
    // WIDTH=1 instance for the truth table
    logic       a1, b1, q1, q_any1, q_reg1, q_valid1, q_sticky1;

    int total = 0;
    int bad   = 0;

    // reference model state for the registered path
    logic [7:0] m_reg;
    logic       m_vld, m_sticky;

    always #5 clk = ~clk;

    or_gate #(.WIDTH(8), .REG_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .clr_sticky(clr_sticky), .q(q8), .q_any(q_any8), .q_reg(q_reg8),
        .q_valid(q_valid8), .q_any_sticky(q_sticky8)
    );

    or_gate #(.WIDTH(8), .REG_EN(1'b0)) dutn (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .clr_sticky(clr_sticky), .q(qn), .q_any(q_anyn), .q_reg(q_regn),
        .q_valid(q_validn), .q_any_sticky(q_stickyn)
    );

    or_gate #(.WIDTH(1), .REG_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid),
        .clr_sticky(clr_sticky), .q(q1), .q_any(q_any1), .q_reg(q_reg1),
        .q_valid(q_valid1), .q_any_sticky(q_sticky1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // combinational outputs against plain a|b
    task automatic check_comb(input string tag);
        logic [7:0] e;
        e = a | b;
        check({tag, ".q"}, {24'd0, q8}, {24'd0, e});
        check({tag, ".q_any"}, {31'd0, q_any8}, {31'd0, (e != 8'd0)});
        check({tag, ".q_nr"}, {24'd0, qn}, {24'd0, e});
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".q_reg"}, {24'd0, q_reg8}, {24'd0, m_reg});
        check({tag, ".q_valid"}, {31'd0, q_valid8}, {31'd0, m_vld});
        check({tag, ".sticky"}, {31'd0, q_sticky8}, {31'd0, m_sticky});
        check({tag, ".nr_regs"}, {22'd0, q_regn, q_validn, q_stickyn}, 32'd0);
    endtask

    // one clock edge, then advance the model with the inputs seen at that edge
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m_vld = in_valid;
            if (in_valid) m_reg = a | b;
            if (in_valid && ((a | b) != 8'd0)) m_sticky = 1'b1;
            else if (clr_sticky) m_sticky = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_reg = 8'd0; m_vld = 1'b0; m_sticky = 1'b0;
    endtask

    initial begin
        logic [1:0] tt;
        rst_n = 1'b0; a = 8'd0; b = 8'd0; in_valid = 1'b0; clr_sticky = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        model_reset();
        #12;
        check_regs("reset");

        // truth table on WIDTH=1, 10 ns per step
        for (int i = 0; i < 4; i++) begin
            tt = i[1:0];
            a1 = tt[1]; b1 = tt[0];
            #10;
            check("tt.q", {31'd0, q1}, {31'd0, (i != 0)});
            check("tt.q_any", {31'd0, q_any1}, {31'd0, (i != 0)});
        end

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single capture A0 | 05
        a = 8'hA0; b = 8'h05; in_valid = 1'b1;
        #1 check_comb("cap");
        tick();
        check("cap.q_reg", {24'd0, q_reg8}, 32'hA5);
        check_regs("cap");
        in_valid = 1'b0; a = 8'h00; b = 8'h00;
        tick();
        check_regs("cap_hold");

        // async reset mid-cycle: regs clear at once, q keeps tracking
        #2 rst_n = 1'b0; a = 8'h30; b = 8'h01;
        model_reset();
        #1;
        check_regs("async_rst");
        check_comb("rst_comb");
        tick();
        check_regs("rst_edge");
        rst_n = 1'b1;

        // sticky behaviour
        a = 8'h00; b = 8'h00; in_valid = 1'b1;
        tick(); check_regs("stk_zero");
        a = 8'h01;
        tick(); check_regs("stk_set");
        in_valid = 1'b0;
        tick(); check_regs("stk_hold");
        clr_sticky = 1'b1;
        tick(); check_regs("stk_clr");
        check("stk_clr_val", {31'd0, q_sticky8}, 32'd0);
        in_valid = 1'b1; a = 8'h80;
        tick(); check_regs("stk_setwins");
        check("stk_setwins_val", {31'd0, q_sticky8}, 32'd1);
        clr_sticky = 1'b0; in_valid = 1'b0;
        tick();

        // back-to-back 01, 02, 04
        in_valid = 1'b1; b = 8'h00;
        for (int i = 0; i < 3; i++) begin
            a = 8'h01 << i;
            tick();
            check("b2b.q_reg", {24'd0, q_reg8}, 32'h1 << i);
            check("b2b.q_valid", {31'd0, q_valid8}, 32'd1);
        end
        in_valid = 1'b0;
        tick(); check_regs("b2b_end");

        // reset lands before the 2nd edge: no further valid
        in_valid = 1'b1; a = 8'h01;
        tick(); check_regs("b2b_r1");
        a = 8'h02;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_regs("b2b_rst");
        tick(); check_regs("b2b_rst_edge");
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick(); check_regs("b2b_after");

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 4) == 0) a = 8'd0;
            in_valid   = 1'($urandom);
            clr_sticky = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            #1 check_comb("rnd");
            tick();
            check_regs("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
